// File: rtl/io_port_receiver_if.sv
// CPU port bank and downstream byte stream for the parallel-port receiver.
// The receiver uses the slave view; the CPU model / consumer uses master.
interface io_port_receiver_if;
  logic [7:0] cpu_ctrl;
  logic [7:0] cpu_data;
  logic [7:0] status;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;

  modport slave (
    input  cpu_ctrl,
    input  cpu_data,
    input  m_ready,
    output status,
    output m_data,
    output m_valid
  );

  modport master (
    output cpu_ctrl,
    output cpu_data,
    output m_ready,
    input  status,
    input  m_data,
    input  m_valid
  );
endinterface

// File: rtl/io_port_receiver.sv
// Peripheral end of the CPU parallel-port protocol: toggle request/ack
// handshake in, first-word fall-through FIFO out on a valid/ready stream.
// The ack toggles for every recognised request, so the CPU never stalls;
// bytes that arrive while the FIFO is full are dropped and flagged.
module io_port_receiver #(
  parameter int AW = 3
) (
  input  logic               clk,
  input  logic               reset,
  io_port_receiver_if.slave  io
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   DEPTH_C = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic          req_q, req_d;
  logic          ack_q, ack_d;
  logic          armed_q, armed_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [DEPTH];

  logic req, flush, pop, push, ovf_set, full, empty;

  // Handshake decode and FIFO next-state; flush overrides push and pop.
  always_comb begin
    flush   = io.cpu_ctrl[7];
    req     = armed_q & (io.cpu_ctrl[0] ^ req_q);
    full    = (count_q == DEPTH_C);
    empty   = (count_q == '0);
    pop     = ~empty & io.m_ready & ~flush;
    push    = req & ~flush & (~full | pop);
    ovf_set = req & ~flush & full & ~pop;

    req_d    = io.cpu_ctrl[0];
    armed_d  = 1'b1;
    ack_d    = ack_q ^ req;
    ovf_d    = ovf_q | ovf_set;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Control and pointer registers, cleared by the async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q    <= 1'b0;
      ack_q    <= 1'b0;
      armed_q  <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      req_q    <= req_d;
      ack_q    <= ack_d;
      armed_q  <= armed_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; not reset because m_data is gated while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= io.cpu_data;
  end

  // Status word and stream outputs decoded from registered state.
  always_comb begin
    io.status  = {4'(count_q), ovf_q, empty, full, ack_q};
    io.m_valid = ~empty;
    io.m_data  = empty ? 8'h00 : mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_io_port_receiver.sv
// Bench for io_port_receiver: a reference model plus a byte scoreboard.
module tb_io_port_receiver;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  io_port_receiver_if bus();

  io_port_receiver #(.AW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb[$];
  bit m_ack = 1'b0;
  bit m_ovf = 1'b0;
  bit m_armed = 1'b0;
  bit m_req_q = 1'b0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: predict with the model, compare popped byte, advance, compare outputs.
  task automatic step();
    bit req, flush, pop, push, ovf_set, ctrl0;
    logic [7:0] d;
    logic [7:0] exp_status;
    int n;
    d     = bus.cpu_data;
    ctrl0 = bus.cpu_ctrl[0];
    flush = bus.cpu_ctrl[7];
    n     = sb.size();
    req   = m_armed && (ctrl0 != m_req_q);
    pop   = (n != 0) && bus.m_ready && !flush;
    push  = req && !flush && ((n < DEPTH) || pop);
    ovf_set = req && !flush && (n == DEPTH) && !pop;
    if (pop) check_eq("pop_data", bus.m_data, sb[0]);
    @(posedge clk);
    #1;
    if (flush) begin
      sb.delete();
      m_ovf = 1'b0;
    end else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back(d);
      if (ovf_set) m_ovf = 1'b1;
    end
    if (req) m_ack = !m_ack;
    m_req_q = ctrl0;
    m_armed = 1'b1;
    n = sb.size();
    exp_status = {4'(n), m_ovf, (n == 0), (n == DEPTH), m_ack};
    check_eq("status", bus.status, exp_status);
    check_eq("m_valid", {7'b0, bus.m_valid}, {7'b0, (n != 0)});
    check_eq("m_data", bus.m_data, (n == 0) ? 8'h00 : sb[0]);
  endtask

  task automatic send(input logic [7:0] d);
    bus.cpu_data = d;
    bus.cpu_ctrl[0] = ~bus.cpu_ctrl[0];
    step();
  endtask

  initial begin
    bus.cpu_ctrl = 8'h01;
    bus.cpu_data = 8'h55;
    bus.m_ready  = 1'b0;

    // Reset, with the request level held high through release
    #3;
    check_eq("rst_status", bus.status, 8'h04);
    check_eq("rst_m_valid", {7'b0, bus.m_valid}, 8'h00);
    check_eq("rst_m_data", bus.m_data, 8'h00);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) step();
    check_eq("t1_no_push_status", bus.status, 8'h04);
    check_eq("t1_ack_low", {7'b0, bus.status[0]}, 8'h00);

    // Single byte in, then consumed
    send(8'hA5);
    check_eq("t2_status", bus.status, 8'h11);
    check_eq("t2_m_data", bus.m_data, 8'hA5);
    bus.m_ready = 1'b1;
    step();
    bus.m_ready = 1'b0;
    check_eq("t2_status_pop", bus.status, 8'h05);

    // Fill, overflow, drain
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i));
    check_eq("t3_full", {7'b0, bus.status[1]}, 8'h01);
    check_eq("t3_count", {4'h0, bus.status[7:4]}, 8'h08);
    send(8'hEE);
    check_eq("t3_ovf", {7'b0, bus.status[3]}, 8'h01);
    check_eq("t3_ack_after_drop", {7'b0, bus.status[0]}, 8'h00);
    bus.m_ready = 1'b1;
    repeat (8) step();
    bus.m_ready = 1'b0;
    check_eq("t3_drained", {4'h0, bus.status[7:4]}, 8'h00);

    // Clear ovf, fill, push and pop together while full
    bus.cpu_ctrl[7] = 1'b1;
    step();
    bus.cpu_ctrl[7] = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
    bus.m_ready = 1'b1;
    send(8'h99);
    bus.m_ready = 1'b0;
    check_eq("t4_count", {4'h0, bus.status[7:4]}, 8'h08);
    check_eq("t4_ovf", {7'b0, bus.status[3]}, 8'h00);
    bus.m_ready = 1'b1;
    repeat (7) step();
    check_eq("t4_tail", bus.m_data, 8'h99);
    step();
    bus.m_ready = 1'b0;

    // Three entries with ovf set, then one flush cycle
    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i));
    send(8'h3F);
    bus.m_ready = 1'b1;
    repeat (5) step();
    bus.m_ready = 1'b0;
    check_eq("t5_pre", {bus.status[7:4], bus.status[3], 3'b0}, 8'h38);
    bus.cpu_ctrl[7] = 1'b1;
    step();
    bus.cpu_ctrl[7] = 1'b0;
    check_eq("t5_status", bus.status, {7'h02, m_ack});
    check_eq("t5_m_valid", {7'b0, bus.m_valid}, 8'h00);

    // Back-to-back push/pop across pointer wrap
    bus.m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(8'h40 + 8'(i));
      check_eq("t6_cnt_le1", {7'b0, (bus.status[7:4] <= 4'd1)}, 8'h01);
    end
    step();
    bus.m_ready = 1'b0;
    check_eq("t6_empty", bus.status, {7'h02, m_ack});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
